// File: rtl/mc_controller_pkg.sv
// mc_pkg: shared states, ALU/cmd/condition encodings and decode helpers for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_ORR = 4'b0011,
                         ALU_EOR = 4'b0100, ALU_ADC = 4'b0101, ALU_SBC = 4'b0110, ALU_MOV = 4'b0111;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                         CMD_ADC = 4'b0101, CMD_SBC = 4'b0110, CMD_CMP = 4'b1010, CMD_ORR = 4'b1100,
                         CMD_MOV = 4'b1101;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3, CC_MI = 4'h4,
                         CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7, CC_HI = 4'h8, CC_LS = 4'h9,
                         CC_GE = 4'ha, CC_LT = 4'hb, CC_GT = 4'hc, CC_LE = 4'hd, CC_AL = 4'he;
  // flags are packed {N,C,Z,V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
    logic n, c, z, v;
    {n, c, z, v} = f;
    case (cond)
      CC_EQ: return z;
      CC_NE: return !z;
      CC_CS: return c;
      CC_CC: return !c;
      CC_MI: return n;
      CC_PL: return !n;
      CC_VS: return v;
      CC_VC: return !v;
      CC_HI: return c && !z;
      CC_LS: return !c || z;
      CC_GE: return n == v;
      CC_LT: return n != v;
      CC_GT: return !z && (n == v);
      CC_LE: return z || (n != v);
      CC_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic cmd_valid(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD, CMD_ADC, CMD_SBC, CMD_CMP, CMD_ORR, CMD_MOV};
  endfunction
  // logic ops and MOV leave V untouched
  function automatic logic cmd_logic(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_EOR, CMD_ORR, CMD_MOV};
  endfunction
  function automatic logic [3:0] alu_op(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      CMD_EOR: return ALU_EOR;
      CMD_ADC: return ALU_ADC;
      CMD_SBC: return ALU_SBC;
      CMD_MOV: return ALU_MOV;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/mc_controller_cond_unit.sv
// cond_unit: architectural NZCV register plus the registered condition-pass bit
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_ld,
  input  logic       flags_ld,
  input  logic       flags_all,
  output logic [3:0] flags,
  output logic       cond_ex
);
  logic [3:0] flags_q, flags_d;
  logic cond_ex_q, cond_ex_d;
  // condition is judged against the flags as they stood before this instruction
  always_comb begin
    flags_d = flags_ld ? (flags_all ? alu_flags : {alu_flags[3:1], flags_q[0]}) : flags_q;
    cond_ex_d = cond_ld ? cond_check(cond, flags_q) : cond_ex_q;
  end
  // flag and condition registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end
  assign flags = flags_q;
  assign cond_ex = cond_ex_q;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control FSM driving the shared-memory datapath
module mc_controller
  import mc_pkg::*;
#(
  parameter int ALUCTL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          ALUFlags,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [1:0]          ResultSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic                RegWrite,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          Flags
);
  state_t state_q, state_d;
  logic pc_w, mem_w, ir_w, reg_w, cond_ld, flags_ld, cond_ex;
  logic [3:0] cmd;
  assign cmd = Funct[4:1];
  cond_unit u_cond (
    .clk(clk), .reset(reset), .cond(Cond), .alu_flags(ALUFlags), .cond_ld(cond_ld),
    .flags_ld(flags_ld), .flags_all(!cmd_logic(cmd)), .flags(Flags), .cond_ex(cond_ex)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else state_q <= state_d;
  end
  // next state and Moore decode; writes raised here are gated by reset below
  always_comb begin
    state_d = FETCH;
    pc_w = 1'b0;
    mem_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    cond_ld = 1'b0;
    flags_ld = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ImmSrc = Op;
    RegSrc = {Op == 2'b01, Op == 2'b10};
    ALUControl = ALU_ADD;
    case (state_q)
      FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        cond_ld = 1'b1;
        state_d = Op == 2'b01 ? MEMADR : Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER)
                : Op == 2'b10 ? BRANCH : FETCH;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = cond_ex;
        pc_w = cond_ex && Rd == 4'hf;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = cond_ex;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB = state_q == EXECUTEI ? 2'b01 : 2'b00;
        ALUControl = alu_op(cmd);
        flags_ld = Funct[0] && cond_ex;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w = cond_ex && cmd_valid(cmd) && cmd != CMD_CMP;
        pc_w = reg_w && Rd == 4'hf;
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
        ResultSrc = 2'b10;
        pc_w = cond_ex;
      end
      default: state_d = FETCH;
    endcase
  end
  assign PCWrite = pc_w && !reset;
  assign MemWrite = mem_w && !reset;
  assign IRWrite = ir_w && !reset;
  assign RegWrite = reg_w && !reset;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed instruction sequences checked against a per-cycle instruction model
module tb_mc_controller;
  logic clk = 1'b0, reset;
  logic [3:0] Cond, Rd, ALUFlags, ALUControl, Flags;
  logic [1:0] Op, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [5:0] Funct;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [3:0] m_flags = 4'b0000;
  typedef struct {
    logic pcw, adr, memw, irw, asa, regw;
    logic [1:0] res, asb, imm, rsrc;
    logic [3:0] ctl, flg;
  } exp_t;
  exp_t ex;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], cy = f[2], z = f[1], v = f[0];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1;           default: return 0;
    endcase
  endfunction

  // {supported, ALU opcode} for a data-processing cmd
  function automatic logic [4:0] ctl_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 5'h10;  4'b0010: return 5'h11;  4'b1010: return 5'h11;
      4'b0000: return 5'h12;  4'b1100: return 5'h13;  4'b0001: return 5'h14;
      4'b0101: return 5'h15;  4'b0110: return 5'h16;  4'b1101: return 5'h17;
      default: return 5'h00;
    endcase
  endfunction

  function automatic int len_of(input logic [1:0] op, input logic [5:0] fn);
    return op == 2'b01 ? (fn[0] ? 5 : 4) : op == 2'b00 ? 4 : op == 2'b10 ? 3 : 2;
  endfunction

  // expected outputs for cycle k of an instruction whose condition outcome is c
  function automatic exp_t model(input int k, input logic [1:0] op, input logic [5:0] fn,
                                 input logic [3:0] rd, input bit c, input logic [3:0] flg);
    exp_t e = '{default: '0};
    logic [4:0] cv = ctl_of(fn[4:1]);
    e.flg = flg;
    if (k == 0) begin
      e.irw = 1; e.pcw = 1; e.asa = 1; e.asb = 2; e.res = 2;
      return e;
    end
    e.imm = op;
    e.rsrc = {op == 2'b01, op == 2'b10};
    if (k == 1) begin
      e.asa = 1; e.asb = 2;
      return e;
    end
    case (op)
      2'b01:
        if (k == 2) e.asb = 1;
        else if (k == 3) begin e.adr = 1; e.memw = !fn[0] && c; end
        else begin e.res = 1; e.regw = c; e.pcw = c && rd == 4'hf; end
      2'b00:
        if (k == 2) begin e.asb = fn[5] ? 2'd1 : 2'd0; e.ctl = cv[3:0]; end
        else begin e.regw = c && cv[4] && fn[4:1] != 4'b1010; e.pcw = e.regw && rd == 4'hf; end
      default: begin e.asb = 1; e.imm = 2; e.rsrc = 1; e.res = 2; e.pcw = c; end
    endcase
    return e;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("PCWrite", PCWrite, ex.pcw);
    chk("AdrSrc", AdrSrc, ex.adr);
    chk("MemWrite", MemWrite, ex.memw);
    chk("IRWrite", IRWrite, ex.irw);
    chk("ResultSrc", ResultSrc, ex.res);
    chk("ALUSrcA", ALUSrcA, ex.asa);
    chk("ALUSrcB", ALUSrcB, ex.asb);
    chk("ImmSrc", ImmSrc, ex.imm);
    chk("RegSrc", RegSrc, ex.rsrc);
    chk("RegWrite", RegWrite, ex.regw);
    chk("ALUControl", ALUControl, ex.ctl);
    chk("Flags", Flags, ex.flg);
  end

  // runs ncyc cycles of one instruction starting in its fetch cycle (posedge+1)
  task automatic issue(input logic [3:0] cd, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic [3:0] af, input int lit, input int ncyc);
    int n = len_of(op, fn);
    bit c = cond_ok(cd, m_flags);
    Cond = cd; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    chk("latency", n, lit);
    for (int k = 0; k < ncyc; k++) begin
      ex = model(k, op, fn, rd, c, m_flags);
      chk_en = 1;
      @(negedge clk);
      if (op == 2'b00 && k == 2 && fn[0] && c)
        m_flags = ctl_of(fn[4:1]) inside {5'h12, 5'h13, 5'h14, 5'h17} ? {af[3:1], m_flags[0]} : af;
      if (!(ncyc < n && k == ncyc - 1)) begin
        @(posedge clk);
        #1;
      end
    end
    if (ncyc == n) chk("refetch", IRWrite, 1'b1);
  endtask

  initial begin
    reset = 1; Cond = 0; Op = 0; Funct = 0; Rd = 0; ALUFlags = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_pcw", PCWrite, 1'b0);
    chk("rst_irw", IRWrite, 1'b0);
    chk("rst_regw", RegWrite, 1'b0);
    chk("rst_asa", ALUSrcA, 1'b1);
    chk("rst_asb", ALUSrcB, 2'b10);
    chk("rst_res", ResultSrc, 2'b10);
    reset = 0;
    issue(4'he, 2'b00, 6'b001000, 4'd1, 4'b0000, 4, 4);   // ADD R1,R2,R3
    issue(4'he, 2'b00, 6'b100101, 4'd0, 4'b0100, 4, 4);   // SUBS R0,R0,#1
    chk("flags_subs", Flags, 4'b0100);
    issue(4'h0, 2'b10, 6'b100000, 4'd0, 4'b1111, 3, 3);   // BEQ not taken
    issue(4'he, 2'b00, 6'b110101, 4'd0, 4'b0010, 4, 4);   // CMP R0,#0
    chk("flags_cmp", Flags, 4'b0010);
    issue(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, 3, 3);   // BEQ taken
    issue(4'he, 2'b01, 6'b011001, 4'd15, 4'b0000, 5, 5);  // LDR R15,[R1,#4]
    issue(4'he, 2'b00, 6'b111011, 4'd2, 4'b1001, 4, 4);   // MOVS keeps V
    chk("flags_movs", Flags, 4'b1000);
    issue(4'he, 2'b11, 6'b000000, 4'd0, 4'b0000, 2, 2);   // undefined
    issue(4'he, 2'b00, 6'b001110, 4'd15, 4'b0000, 4, 4);  // unsupported cmd
    issue(4'h0, 2'b01, 6'b011000, 4'd3, 4'b0000, 4, 4);   // STREQ skipped
    issue(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000, 4, 4);   // STR
    issue(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000, 4, 3);   // STR cut short in MEMADR
    #1;
    chk_en = 0;
    reset = 1;
    #1;
    chk("abort_flags", Flags, 4'b0000);
    chk("abort_memw", MemWrite, 1'b0);
    chk("abort_pcw", PCWrite, 1'b0);
    chk("abort_adr", AdrSrc, 1'b0);
    chk("abort_asa", ALUSrcA, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_memw", MemWrite, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 0;
    m_flags = 4'b0000;
    issue(4'he, 2'b00, 6'b001000, 4'd1, 4'b0000, 4, 4);   // ADD after reset
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the ARM-subset datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Holds the architectural NZCV flag register and evaluates condition codes.
- Drives every select and write-enable of the multicycle datapath, which shares one memory, one ALU and one instruction register across cycles.

Parameters:
- ALUCTL_W, 4, width of the ALUControl bus; fixed at 4 to match the ALU opcode set.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; I-bit at [5], cmd at [4:1], S/L bit at [0]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  ALU flags {N,C,Z,V}; [3]=N, [2]=C, [1]=Z, [0]=V
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result select: 00=ALUOut reg, 01=Data reg, 10=ALU direct
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  00=8-bit DP immediate, 01=12-bit memory offset, 10=24-bit branch
- RegSrc  out  2  [0]=RA1 forced to R15, [1]=RA2 taken from Rd
- RegWrite  out  1  register file write
- ALUControl  out  ALUCTL_W  ALU opcode
- Flags  out  4  current architectural flags, for debug and carry-in

Behaviour:
- One state register, updated on the clk rising edge.
- Reset (async, high): state=FETCH, Flags=4'b0000, CondExE=0.
- While reset is high, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0. Other outputs take their FETCH values.
- All outputs are Moore decodes of state, except the write enables, which are additionally gated by CondExE.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional). Next state is DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ALUControl=ADD; this forms PC+8 for the R15 read.
  - RegSrc={Op==01, Op==10}; ImmSrc=Op.
  - CondExE <= condition result from the registered Flags and Cond. Codes 0000–1101 follow ARM semantics, 1110=always, 1111=never.
  - Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (treated as NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD (positive offset only). Next state: Funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondExE.
  - If Rd=15, PCWrite=CondExE as well (load to PC).
  - Next state is FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondExE. Next state is FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=0; ALUSrcB=00 for EXECUTER, 01 for EXECUTEI; ALUControl from cmd. Next state is ALUWB.
  - Flags <= ALUFlags when Funct[0]=1 and CondExE=1.
  - For ADD/SUB/ADC/SBC/CMP all four flags update; for logic ops and MOV only N, Z and C update and V is kept.
- ALUWB: ResultSrc=00, RegWrite=CondExE and not CMP.
  - If Rd=15 and RegWrite, PCWrite=1.
  - Next state is FETCH.
- BRANCH: ALUSrcA=0, RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=CondExE. Next state is FETCH.
- cmd -> ALUControl mapping:
  - 0100 -> ADD 0000
  - 0010 -> SUB 0001
  - 1010 -> CMP 0001
  - 0000 -> AND 0010
  - 1100 -> ORR 0011
  - 0001 -> EOR 0100
  - 0101 -> ADC 0101
  - 0110 -> SBC 0110
  - 1101 -> MOV 0111 (pass B)
  - Any other cmd -> ADD with RegWrite suppressed.
- Latency in cycles: LDR 5, STR 4, DP 4, B 3, undefined 2.
- A failed condition still walks the full state path, with all writes suppressed.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after reset rises.

Decomposition:
- Package mc_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH;
  - ALUControl opcode constants;
  - cmd constants;
  - condition-code constants.
- Sub-module cond_unit: the Flags register, the CondExE register and the combinational condition check.

Test Plan:
- Reset, then ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000) -> states F, D, ER, AW. RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH; ALUControl=0000 in EXECUTER.
- SUBS R0,R0,#1 with ALUFlags=0100 (Z=0, C=1), then BEQ -> Flags=0100 after EXECUTEI. BEQ reaches BRANCH with PCWrite=0; next FETCH follows 3 cycles after BEQ fetch.
- CMP with ALUFlags=0010 (Z=1), then BEQ -> Flags=0010; RegWrite=0 in ALUWB; BRANCH asserts PCWrite=1.
- LDR R15,[R1,#4] -> 5 cycles; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1, PCWrite=1.
- STR with Cond=0000 and Flags Z=0 -> MEMWRITE reached, MemWrite=0, FETCH next.
- Reset pulsed during MEMADR of an STR -> state=FETCH and Flags=0 immediately; MemWrite never asserted; normal fetch resumes after release.
